uart_echo_fifo: RTL
===================

Name: uart_echo_fifo

Overview:
- Parametrised successor to the single-byte UART echo.
- Receives asynchronous serial frames on rxd, validates framing and parity, and buffers accepted bytes in a FIFO.
- Retransmits the buffered bytes on txd in order.
- Adds a configurable frame format, an echo buffer, error and overflow flags, and transmit pause for flow control and test.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; BIT_CNT = round(CLK_FREQ/BAUD) = 434 at defaults
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, stop bits transmitted, legal 1 or 2; RX checks the first stop bit only
FIFO_DEPTH, 16, echo buffer entries, power of 2, >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
rxd  input  1  serial input, idle high, asynchronous to clk
tx_pause  input  1  high: TX starts no new frame; a frame in progress completes
txd  output  1  serial output, idle high
tx_busy  output  1  high from start bit through last stop bit
rx_frame_err  output  1  one-cycle pulse when the stop bit samples 0
rx_parity_err  output  1  one-cycle pulse on parity mismatch
fifo_overflow  output  1  one-cycle pulse when a valid byte arrives while the FIFO is full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (async assert, released on a clk edge):
  - txd=1, tx_busy=0, all pulses 0, fifo_count=0.
  - FIFO pointers cleared and both FSMs set to IDLE.
  - The rxd synchroniser flops are preset to 1.
  - Reset mid-frame aborts RX and TX; txd goes high immediately, not on a clock edge.
- rxd synchroniser: two flops, giving a fixed 2-cycle input latency.
- RX FSM:
  - IDLE -> START on a synchronised falling edge.
  - START: at BIT_CNT/2 cycles re-samples; if high (glitch) -> IDLE with no flags, else -> DATA.
  - DATA: samples every BIT_CNT cycles at mid-bit, LSB first, DATA_BITS samples.
  - PARITY: present only if PARITY != 0; one sample.
  - STOP: one sample, then -> IDLE.
  - Stop sample 0: pulse rx_frame_err and discard the byte; this has priority over the parity error.
  - Parity mismatch with a good stop bit: pulse rx_parity_err and discard the byte.
  - Otherwise push the byte in the stop-sample cycle. Unused upper bits are zero when DATA_BITS < 8.
  - RX returns to IDLE at the stop-bit midpoint, so a start edge arriving half a bit later is caught.
- FIFO:
  - Push in cycle N makes fifo_count increment at N+1.
  - Full and push with no pop: byte dropped, fifo_overflow pulses, contents unchanged.
  - Full with push and pop in the same cycle: both occur, count unchanged, no overflow.
  - Pop occurs only when count is nonzero, so there is no underflow.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM:
  - IDLE: when fifo_count != 0 and tx_pause=0, pop the byte and -> START. txd falls the cycle after the pop; byte pushed at N gives txd low at N+2.
  - START, DATA (LSB first), PARITY (if enabled), STOP (STOP_BITS), then -> IDLE. Each bit lasts exactly BIT_CNT cycles.
  - Back-to-back frames carry no idle gap when the FIFO is not empty.
  - tx_pause asserted mid-frame takes effect at the next IDLE decision.
- Parity: odd means data XOR parity = 1; even means data XOR parity = 0.

Test Plan:
1. Defaults; rxd frame 0x22 (bit time 8680 ns) -> one txd frame 0x22; txd falls 4123..4127 clk after the rxd start edge; no flags; fifo_count returns to 0.
2. Defaults; frames 0x22, 0x22, 0x11, 0x33, 0x34 back-to-back -> txd echoes the same sequence in order, 10 bit times per frame, no overflow.
3. tx_pause=1; send 18 bytes 0x00..0x11 -> fifo_count reaches 16, fifo_overflow pulses twice; release pause -> txd emits 0x00..0x0F only.
4. PARITY=2; send 0x33 with parity bit 1 -> rx_parity_err single pulse, no echo. Send 0x33 with parity 0 -> echo includes parity 0.
5. Send 0x55 with stop bit 0 -> rx_frame_err pulse, no push. Separately, rxd low for 100 ns -> no flags, no echo.
6. Assert rst mid-TX of 0xA5 with 3 bytes queued -> txd=1 asynchronously, fifo_count=0; after release, no further txd activity.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// UART receiver feeding an echo FIFO that is drained by a UART transmitter.
// Frame format, line rate and buffer depth are parameters; errors and overflow are flagged.
module uart_echo_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          tx_pause,
    output logic                          txd,
    output logic                          tx_busy,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          fifo_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BIT_CNT = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W   = $clog2(BIT_CNT + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CNT / 2 - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    logic rxd_s1, rxd_s2, rxd_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    rx_state_t              rx_state;
    logic [CNT_W-1:0]       rx_cnt;
    logic [2:0]             rx_idx;
    logic [DATA_BITS-1:0]   rx_sh;
    logic                   rx_par;
    logic                   rx_tick, par_ok, rx_push;

    assign rx_tick = (rx_cnt == BIT_LAST);

    always_comb begin
        par_ok = 1'b1;
        if (PARITY == 1)
            par_ok = (^rx_sh) ^ rx_par;
        else if (PARITY == 2)
            par_ok = ~((^rx_sh) ^ rx_par);
    end

    assign rx_push = (rx_state == RX_STOP) && rx_tick && rxd_s2 && par_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_sh         <= '0;
            rx_par        <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_d && !rxd_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rxd_s2, rx_sh[DATA_BITS-1:1]};
                        if (rx_idx == IDX_LAST)
                            rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        else
                            rx_idx <= rx_idx + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_par   <= rxd_s2;
                        rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Back to idle at the stop midpoint so the next start edge is not missed.
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (!rxd_s2)
                            rx_frame_err <= 1'b1;
                        else if (!par_ok)
                            rx_parity_err <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] rd_data;
    logic                 full, do_push, tx_pop, tx_last, tx_tick;

    assign full    = (fifo_count == FULL_CNT);
    assign do_push = rx_push && (!full || tx_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= rx_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            fifo_overflow <= rx_push && full && !tx_pop;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !tx_pop)
                fifo_count <= fifo_count + 1'b1;
            else if (!do_push && tx_pop)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [2:0]           tx_idx;
    logic                 tx_stop_idx;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;

    assign tx_tick = (tx_cnt == BIT_LAST);
    assign tx_last = (tx_state == TX_STOP) && tx_tick && (tx_stop_idx == STOP_LAST);
    // Popping in the last stop cycle lets queued frames follow with no idle gap.
    assign tx_pop  = ((tx_state == TX_IDLE) || tx_last) && (fifo_count != '0) && !tx_pause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
            tx_sh       <= '0;
            tx_par      <= 1'b0;
            txd         <= 1'b1;
            tx_busy     <= 1'b0;
        end else if (tx_pop) begin
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_sh    <= rd_data;
            tx_par   <= (PARITY == 1) ? ~(^rd_data) : (^rd_data);
            txd      <= 1'b0;
            tx_busy  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: ;
                TX_START: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_state <= TX_DATA;
                        txd      <= tx_sh[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
                            if (PARITY != 0) begin
                                tx_state <= TX_PARITY;
                                txd      <= tx_par;
                            end else begin
                                tx_state    <= TX_STOP;
                                tx_stop_idx <= 1'b0;
                                txd         <= 1'b1;
                            end
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                            tx_sh  <= tx_sh >> 1;
                            txd    <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (tx_tick) begin
                        tx_cnt      <= '0;
                        tx_state    <= TX_STOP;
                        tx_stop_idx <= 1'b0;
                        txd         <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_stop_idx == STOP_LAST) begin
                            tx_state <= TX_IDLE;
                            tx_busy  <= 1'b0;
                        end else begin
                            tx_stop_idx <= tx_stop_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule
